// File: rtl/mac_fsm_pkg.sv
// Shared types for the MAC job sequencer.
//  mac_fsm_state_t : sequencer states
//  mac_fsm_cfg_t   : job configuration latched on an accepted trigger
// The cfg struct is sized for the largest supported widths. mac_fsm casts
// its parameterised ports into and out of these fields, so the parameters
// must not exceed the *_MAX_W values below.
package mac_fsm_pkg;

  localparam int unsigned LEN_MAX_W   = 16;
  localparam int unsigned SHIFT_MAX_W = 8;
  localparam int unsigned CNT_MAX_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    COMPUTE,
    UPDATE,
    FINISH
  } mac_fsm_state_t;

  typedef struct packed {
    logic                   simple_mul;
    logic [LEN_MAX_W-1:0]   len;
    logic [SHIFT_MAX_W-1:0] shift;
    logic [CNT_MAX_W-1:0]   nb_iter;
  } mac_fsm_cfg_t;

endpackage

// File: rtl/mac_fsm_counter.sv
// Generic up-counter with synchronous clear, enable and terminal-count compare.
//  clk_i, rst_i : clock, async active-high reset
//  clear_i      : synchronous clear (wins over en_i)
//  en_i         : increment enable
//  tc_i         : terminal-count value
//  cnt_o        : current count
//  tc_o         : cnt_o == tc_i
module mac_fsm_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_i);

endmodule

// File: rtl/mac_fsm.sv
// Job sequencer for the MAC engine: latches a job configuration on trigger,
// requests a streamer load per iteration, runs the engine until the expected
// number of output handshakes has been seen, repeats nb_iter times and then
// pulses done_o.
//  Control in : clk_i, rst_i (async, active-high), clear_i (sync), trigger_i
//  Config in  : cfg_simple_mul_i, cfg_len_i, cfg_shift_i, cfg_nb_iter_i
//  Streamer   : strm_req_o / strm_ready_i
//  Snoop      : d_valid_i, d_ready_i (engine output stream)
//  Engine out : eng_clear_o, eng_enable_o, eng_start_o, eng_simple_mul_o,
//               eng_len_o, eng_shift_o
//  Status     : busy_o, done_o, iter_o, err_o
// Optional macro MAC_FSM_TIMEOUT_EN adds a COMPUTE watchdog driving err_o;
// without it err_o is tied low and COMPUTE waits indefinitely.
module mac_fsm
  import mac_fsm_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned LEN_W     = 11,
  parameter int unsigned SHIFT_W   = 5,
  parameter int unsigned TIMEOUT_W = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               trigger_i,
  input  logic               cfg_simple_mul_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic [SHIFT_W-1:0] cfg_shift_i,
  input  logic [CNT_W-1:0]   cfg_nb_iter_i,
  output logic               strm_req_o,
  input  logic               strm_ready_i,
  input  logic               d_valid_i,
  input  logic               d_ready_i,
  output logic               eng_clear_o,
  output logic               eng_enable_o,
  output logic               eng_start_o,
  output logic               eng_simple_mul_o,
  output logic [LEN_W-1:0]   eng_len_o,
  output logic [SHIFT_W-1:0] eng_shift_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   iter_o,
  output logic               err_o
);

  mac_fsm_state_t state_q, state_d;
  mac_fsm_cfg_t   cfg_q, cfg_d;
  logic           start_q, start_d;

  logic               hs, in_compute, trig_acc, final_hs;
  logic [LEN_W-1:0]   len_l, out_tc;
  logic [CNT_W-1:0]   nb_l, iter_cnt;
  logic               iter_last, out_last, wd_expire;

  assign hs         = d_valid_i & d_ready_i;
  assign in_compute = (state_q == COMPUTE);
  assign trig_acc   = (state_q == IDLE) & trigger_i & ~clear_i;

  assign len_l  = LEN_W'(cfg_q.len);
  assign nb_l   = CNT_W'(cfg_q.nb_iter);
  // Terminal count is the index of the last expected handshake.
  assign out_tc = cfg_q.simple_mul ? (len_l - 1'b1) : '0;

  mac_fsm_counter #(.W(CNT_W)) u_iter_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i | trig_acc),
    .en_i    (state_q == UPDATE),
    .tc_i    (nb_l - 1'b1),
    .cnt_o   (iter_cnt),
    .tc_o    (iter_last)
  );

  // Held at zero outside COMPUTE, so every iteration starts from 0 and
  // handshakes outside COMPUTE are ignored.
  mac_fsm_counter #(.W(LEN_W)) u_out_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i | ~in_compute),
    .en_i    (in_compute & hs),
    .tc_i    (out_tc),
    .cnt_o   (),
    .tc_o    (out_last)
  );

  assign final_hs = in_compute & hs & out_last;

`ifdef MAC_FSM_TIMEOUT_EN
  logic err_q, err_d;
  logic wd_tc;

  // Compare against 2**W-2: the count would reach 2**W-1 on this edge, so
  // FINISH is entered exactly 2**W-1 cycles after COMPUTE entry.
  mac_fsm_counter #(.W(TIMEOUT_W)) u_wd_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i | ~in_compute | hs),
    .en_i    (in_compute),
    .tc_i    ({{(TIMEOUT_W-1){1'b1}}, 1'b0}),
    .cnt_o   (),
    .tc_o    (wd_tc)
  );

  assign wd_expire = in_compute & ~hs & wd_tc;

  always_comb begin
    err_d = err_q;
    if (clear_i || trig_acc)                      err_d = 1'b0;
    else if (wd_expire && !final_hs)              err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign wd_expire = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger_i) begin
            cfg_d.simple_mul = cfg_simple_mul_i;
            cfg_d.len        = LEN_MAX_W'(cfg_len_i);
            cfg_d.shift      = SHIFT_MAX_W'(cfg_shift_i);
            cfg_d.nb_iter    = CNT_MAX_W'(cfg_nb_iter_i);
            state_d = ((cfg_nb_iter_i == '0) || (cfg_len_i == '0)) ? FINISH : REQ;
          end
        end
        REQ:     if (strm_ready_i) state_d = COMPUTE;
        COMPUTE: begin
          if (final_hs)       state_d = UPDATE;
          else if (wd_expire) state_d = FINISH;
        end
        // iter_last is evaluated before the increment lands.
        UPDATE:  state_d = iter_last ? FINISH : REQ;
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign start_d = (state_q == REQ) & (state_d == COMPUTE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      start_q <= start_d;
    end
  end

  assign strm_req_o       = (state_q == REQ);
  assign eng_enable_o     = in_compute;
  assign eng_start_o      = start_q;
  assign eng_clear_o      = clear_i | (state_q == UPDATE) | (state_q == FINISH);
  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == FINISH);
  assign iter_o           = iter_cnt;
  assign eng_simple_mul_o = cfg_q.simple_mul;
  assign eng_len_o        = len_l;
  assign eng_shift_o      = SHIFT_W'(cfg_q.shift);

endmodule
